// File: rtl/load_unit_if.sv
// Load unit bus bundle: request, memory read and response channels.
// slave = the load unit side, master = requester / memory side.
interface load_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size,
    input  req_unsigned, mem_rdata,
    input  mem_rvalid, rsp_ready,
    output req_ready, mem_rd_en, mem_addr,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_size,
    output req_unsigned, mem_rdata,
    output mem_rvalid, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_unit.sv
// Load unit: one aligned read per request, field extract + extend.
// Ports: clk, reset (async active-low), bus (load_unit_if.slave).
module load_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic        clk,
  input logic        reset,
  load_unit_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [LB-1:0]     off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        err_q, err_d;

  logic [LB-1:0]     roff, amask;
  logic              illegal, misal;
  logic [DATA_W-1:0] sh, msk, ext;
  logic [6:0]        fw;
  logic              sgn;

  assign roff    = bus.req_addr[LB-1:0];
  assign amask   = ~({LB{1'b1}} << bus.req_size);
  assign illegal = int'(bus.req_size) > LB;
  assign misal   = (roff & amask) != '0;

  // Field sits at the bottom after the shift;
  // msk covers its width, msb isolates its top bit.
  assign sh  = bus.mem_rdata >> {off_q, 3'b000};
  assign fw  = 7'd8 << size_q;
  assign msk = ~({DATA_W{1'b1}} << fw);
  assign sgn = ~uns_q & (|(sh & msk & ~(msk >> 1)));
  assign ext = (sh & msk) | (~msk & {DATA_W{sgn}});

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_rd_en = (state_q == ISSUE);
  assign bus.mem_addr  = maddr_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    maddr_d = maddr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d  = roff;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          if (illegal) begin
            state_d = RESP;
            err_d   = 2'd2;
            data_d  = '0;
          end else if (misal) begin
            state_d = RESP;
            err_d   = 2'd1;
            data_d  = '0;
          end else begin
            state_d = ISSUE;
            maddr_d = {bus.req_addr[ADDR_W-1:LB],
                       {LB{1'b0}}};
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the last WAIT cycle beats the timeout.
        if (bus.mem_rvalid) begin
          data_d  = ext;
          err_d   = 2'd0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 2'd3;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      maddr_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit at DATA_W=32 and DATA_W=64.
// Both instances use TIMEOUT=4 and share clk/reset.
module tb_load_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  load_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  load_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset(reset), .bus(b32.slave)
  );
  load_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u64 (
    .clk(clk), .reset(reset), .bus(b64.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit load; rvalid on WAIT cycle dly (0 = never).
  task automatic load32(input logic [31:0] a,
                        input logic [1:0] sz,
                        input logic u,
                        input logic [31:0] rd,
                        input int dly,
                        output logic [31:0] data,
                        output logic [1:0] err,
                        output int n,
                        output int rds,
                        output logic [31:0] maddr);
    int w;
    w = -1;
    rds = 0;
    maddr = '0;
    b32.req_addr = a;
    b32.req_size = sz;
    b32.req_unsigned = u;
    b32.mem_rdata = rd;
    b32.req_valid = 1'b1;
    chk("req_ready", 64'(b32.req_ready), 64'd1);
    cyc();
    b32.req_valid = 1'b0;
    n = 1;
    while (!b32.rsp_valid && n < 40) begin
      if (b32.mem_rd_en) begin
        rds++;
        maddr = b32.mem_addr;
        w = 0;
      end else if (w >= 0) begin
        w++;
      end
      b32.mem_rvalid = (dly > 0) && (w == dly);
      cyc();
      b32.mem_rvalid = 1'b0;
      n++;
    end
    chk("rsp_valid", 64'(b32.rsp_valid), 64'd1);
    data = b32.rsp_data;
    err = b32.rsp_err;
  endtask

  task automatic retire32();
    b32.rsp_ready = 1'b1;
    cyc();
    b32.rsp_ready = 1'b0;
  endtask

  task automatic load64(input logic [31:0] a,
                        input logic [1:0] sz,
                        input logic u,
                        input logic [63:0] rd,
                        input logic [63:0] exp,
                        input string tag);
    b64.req_addr = a;
    b64.req_size = sz;
    b64.req_unsigned = u;
    b64.req_valid = 1'b1;
    chk({tag, "_rdy"}, 64'(b64.req_ready), 64'd1);
    cyc();
    b64.req_valid = 1'b0;
    chk({tag, "_rd"}, 64'(b64.mem_rd_en), 64'd1);
    chk({tag, "_ma"}, 64'(b64.mem_addr), 64'h1000);
    cyc();
    b64.mem_rdata = rd;
    b64.mem_rvalid = 1'b1;
    cyc();
    b64.mem_rvalid = 1'b0;
    chk({tag, "_v"}, 64'(b64.rsp_valid), 64'd1);
    chk({tag, "_d"}, b64.rsp_data, exp);
    chk({tag, "_e"}, 64'(b64.rsp_err), 64'd0);
    b64.rsp_ready = 1'b1;
    cyc();
    b64.rsp_ready = 1'b0;
  endtask

  task automatic chk_rst32(input string tag);
    chk({tag, "_rdy"}, 64'(b32.req_ready), 64'd1);
    chk({tag, "_rd"}, 64'(b32.mem_rd_en), 64'd0);
    chk({tag, "_ma"}, 64'(b32.mem_addr), 64'd0);
    chk({tag, "_v"}, 64'(b32.rsp_valid), 64'd0);
    chk({tag, "_d"}, 64'(b32.rsp_data), 64'd0);
    chk({tag, "_e"}, 64'(b32.rsp_err), 64'd0);
  endtask

  logic [31:0] d, ma;
  logic [1:0]  e;
  int          lat, nrd;

  initial begin
    b32.req_valid = 0; b32.req_addr = '0;
    b32.req_size = '0; b32.req_unsigned = 0;
    b32.mem_rdata = '0; b32.mem_rvalid = 0;
    b32.rsp_ready = 0;
    b64.req_valid = 0; b64.req_addr = '0;
    b64.req_size = '0; b64.req_unsigned = 0;
    b64.mem_rdata = '0; b64.mem_rvalid = 0;
    b64.rsp_ready = 0;
    #2;
    chk_rst32("rst");
    chk("rst64_v", 64'(b64.rsp_valid), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();

    load32(32'h1003, 2'd0, 1'b0, 32'h80FFEE11, 1,
           d, e, lat, nrd, ma);
    chk("sb_data", 64'(d), 64'hFFFFFF80);
    chk("sb_err", 64'(e), 64'd0);
    chk("sb_lat", 64'(lat), 64'd3);
    chk("sb_nrd", 64'(nrd), 64'd1);
    chk("sb_maddr", 64'(ma), 64'h1000);
    retire32();

    load32(32'h2002, 2'd1, 1'b1, 32'hBEEF1234, 1,
           d, e, lat, nrd, ma);
    chk("uh_data", 64'(d), 64'h0000BEEF);
    chk("uh_maddr", 64'(ma), 64'h2000);
    retire32();
    load32(32'h2002, 2'd1, 1'b0, 32'hBEEF1234, 1,
           d, e, lat, nrd, ma);
    chk("sh_data", 64'(d), 64'hFFFFBEEF);
    retire32();

    load32(32'h3001, 2'd2, 1'b0, 32'hDEADBEEF, 1,
           d, e, lat, nrd, ma);
    chk("mis_err", 64'(e), 64'd1);
    chk("mis_data", 64'(d), 64'd0);
    chk("mis_lat", 64'(lat), 64'd1);
    chk("mis_nrd", 64'(nrd), 64'd0);
    retire32();

    load32(32'h3001, 2'd3, 1'b0, 32'hDEADBEEF, 1,
           d, e, lat, nrd, ma);
    chk("ill_err", 64'(e), 64'd2);
    chk("ill_data", 64'(d), 64'd0);
    chk("ill_nrd", 64'(nrd), 64'd0);
    retire32();

    load32(32'h4000, 2'd2, 1'b0, 32'h12345678, 0,
           d, e, lat, nrd, ma);
    chk("to_err", 64'(e), 64'd3);
    chk("to_data", 64'(d), 64'd0);
    chk("to_lat", 64'(lat), 64'd6);
    retire32();

    load32(32'h4000, 2'd2, 1'b0, 32'h12345678, 4,
           d, e, lat, nrd, ma);
    chk("late_err", 64'(e), 64'd0);
    chk("late_data", 64'(d), 64'h12345678);
    chk("late_lat", 64'(lat), 64'd6);
    retire32();

    load32(32'h1003, 2'd0, 1'b0, 32'h80FFEE11, 1,
           d, e, lat, nrd, ma);
    b32.req_addr = 32'h2002;
    b32.req_size = 2'd1;
    b32.req_unsigned = 1'b1;
    b32.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 64'(b32.rsp_data), 64'hFFFFFF80);
      chk("bp_err", 64'(b32.rsp_err), 64'd0);
      chk("bp_rdy", 64'(b32.req_ready), 64'd0);
      chk("bp_v", 64'(b32.rsp_valid), 64'd1);
      cyc();
    end
    b32.rsp_ready = 1'b1;
    cyc();
    b32.rsp_ready = 1'b0;
    chk("bp_idle", 64'(b32.req_ready), 64'd1);
    chk("bp_v0", 64'(b32.rsp_valid), 64'd0);
    cyc();
    b32.req_valid = 1'b0;
    chk("bp_rd", 64'(b32.mem_rd_en), 64'd1);
    chk("bp_ma", 64'(b32.mem_addr), 64'h2000);
    cyc();
    b32.mem_rdata = 32'hBEEF1234;
    b32.mem_rvalid = 1'b1;
    cyc();
    b32.mem_rvalid = 1'b0;
    chk("bp2_v", 64'(b32.rsp_valid), 64'd1);
    chk("bp2_data", 64'(b32.rsp_data), 64'h0000BEEF);
    retire32();

    b32.req_addr = 32'h1003;
    b32.req_size = 2'd0;
    b32.req_unsigned = 1'b0;
    b32.mem_rdata = 32'h80FFEE11;
    b32.req_valid = 1'b1;
    cyc();
    b32.req_valid = 1'b0;
    cyc();
    chk("wr_wait_rd", 64'(b32.mem_rd_en), 64'd0);
    reset = 1'b0;
    #1;
    chk_rst32("wr_rst");
    cyc();
    reset = 1'b1;
    b32.mem_rvalid = 1'b1;
    cyc();
    b32.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_v", 64'(b32.rsp_valid), 64'd0);
      chk("wr_rdy", 64'(b32.req_ready), 64'd1);
      chk("wr_rd", 64'(b32.mem_rd_en), 64'd0);
      chk("wr_d", 64'(b32.rsp_data), 64'd0);
      cyc();
    end

    load64(32'h1007, 2'd0, 1'b0, 64'h80AABBCCDDEEFF11,
           64'hFFFFFFFFFFFFFF80, "b64s");
    load64(32'h1007, 2'd0, 1'b1, 64'h80AABBCCDDEEFF11,
           64'h0000000000000080, "b64u");
    load64(32'h1000, 2'd3, 1'b0, 64'h80AABBCCDDEEFF11,
           64'h80AABBCCDDEEFF11, "b64d");
    load64(32'h1004, 2'd2, 1'b0, 64'h80AABBCCDDEEFF11,
           64'hFFFFFFFF80AABBCC, "b64w");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
